// File: rtl/seg_pkg.sv
// Shared widths and FSM state type for the binary-to-digits converter.
package seg_pkg;

    localparam int DIGIT_W    = 5;
    localparam int NUM_DIGITS = 5;
    localparam int BCD_W      = 20;
    localparam int CNT_W      = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/dabble_adjust.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets +3 before the shift.
module dabble_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/binary_to_digits.sv
// Converts a binary value into five digit codes, either as a hex nibble split
// (single cycle) or as BCD via a sequential double-dabble, one bit per cycle.
module binary_to_digits #(
    parameter int VALUE_W    = 16,
    parameter int NUM_DIGITS = seg_pkg::NUM_DIGITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        hex_mode,
    input  logic [VALUE_W-1:0]          value,
    output logic                        busy,
    output logic                        done,
    output logic [seg_pkg::DIGIT_W-1:0] digit0,
    output logic [seg_pkg::DIGIT_W-1:0] digit1,
    output logic [seg_pkg::DIGIT_W-1:0] digit2,
    output logic [seg_pkg::DIGIT_W-1:0] digit3,
    output logic [seg_pkg::DIGIT_W-1:0] digit4
);

    import seg_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(VALUE_W - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [VALUE_W-1:0] sh_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   res_q;
    logic               fin_q;
    logic [BCD_W-1:0]   dig_q;
    logic               busy_q;
    logic               done_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_d;
    logic [VALUE_W-1:0] sh_d;
    logic               accept;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_adj
        dabble_adjust u_adj (
            .nib_i (bcd_q[4*k +: 4]),
            .nib_o (bcd_adj[4*k +: 4])
        );
    end

    always_comb begin
        bcd_d  = (bcd_adj << 1) | BCD_W'(sh_q[VALUE_W-1]);
        sh_d   = sh_q << 1;
        accept = start && (state_q == IDLE);
    end

    // res_q is the internal result; it reaches the visible digits one cycle
    // later together with done, so outputs never show a partial value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            res_q   <= '0;
            fin_q   <= 1'b0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fin_q  <= 1'b0;
            busy_q <= (state_q == SHIFT);
            done_q <= fin_q;
            if (fin_q) begin
                dig_q <= res_q;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q <= '0;
                        if (hex_mode) begin
                            res_q <= BCD_W'(value);
                            fin_q <= 1'b1;
                        end else begin
                            sh_q    <= value;
                            bcd_q   <= '0;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_ITER) begin
                        res_q   <= bcd_d;
                        fin_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign digit0 = {1'b0, dig_q[3:0]};
    assign digit1 = {1'b0, dig_q[7:4]};
    assign digit2 = {1'b0, dig_q[11:8]};
    assign digit3 = {1'b0, dig_q[15:12]};
    assign digit4 = {1'b0, dig_q[19:16]};

endmodule
